seq_alu: RTL
============

# seq_alu

Parametrised, handshaked successor to the 8-bit single-cycle ALU in the CPU datapath. Executes logical, arithmetic and shift operations in one cycle and an unsigned multiply iteratively in WIDTH cycles. Produces a registered result with status flags, and sits between the instruction decoder (issue side) and the register-file write-back (result side). Valid/ready on both sides allows the control unit to stall on multiply without a fixed-latency assumption.

## Interface
- WIDTH, 8, operand/result width in bits (≥4, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  issue request
- in_ready  output  1  block can accept an operation this cycle
- opcode  input  4  operation select
- operandA  input  WIDTH  first operand (two's complement)
- operandB  input  WIDTH  second operand / shift amount
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes result this cycle
- result  output  WIDTH  registered result
- flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative (result MSB), carry, signed overflow
- illegal  output  1  opcode was undefined (qualified by out_valid)

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 NAND, 0011 NOR: c=v=0.
  - 0100 ADD: c = carry out, v = signed overflow.
  - 0101 SUB (A−B): c = borrow (A<B unsigned), v = signed overflow.
  - 0110 SHL, 0111 SHR (arithmetic): amount = operandB[SHW-1:0]; c = last bit shifted out (0 if amount 0); v=0.
  - 1000 MUL: unsigned A×B, result = low WIDTH bits; c = OR of high WIDTH bits; v=0.
  - 1001–1111: result 0, z=1, n=c=v=0, illegal=1.
- z and n are always derived from the final result. illegal=0 for every defined opcode.
- Operands and opcode are captured on the accept cycle; later input changes have no effect.
- FSM states:
  - IDLE: in_ready=1. Accept of a non-MUL op → DONE, with result/flags registered on the same edge. Accept of MUL → MUL, with the accumulator cleared, the multiplier loaded and the counter set to WIDTH.
  - MUL: one shift-add step per cycle (2·WIDTH accumulator); the counter decrements. On the step where the counter reaches 0, load result/flags → DONE. in_ready=0.
  - DONE: out_valid=1; result/flags held stable until out_ready. in_ready = out_ready. On out_ready, a simultaneous accept is handled as from IDLE (→DONE or →MUL); otherwise → IDLE.
- Reset (async, any state, including mid-MUL): state=IDLE; result=0; all flags=0; illegal=0; out_valid=0; the in-flight multiply is discarded.

## Timing
- Non-MUL latency: accept at edge k → out_valid=1 after edge k.
- MUL latency: accept at edge k → out_valid=1 after edge k+WIDTH.
- Throughput: 1 op/cycle for non-MUL ops when out_ready is held high (DONE→DONE back-to-back).
- out_valid deasserts on the edge where out_ready=1 with no new accept.
- in_ready is combinational from state and out_ready. No other combinational input→output path exists.
- Every output changes only on clock edges or on reset assertion.

## Test plan
- Reset mid-MUL: assert reset_n=0 during MUL cycle 3 → immediately out_valid=0, result=0, flags 0, in_ready=1 after release.
- WIDTH=8, ADD 0x7F+0x01 → 0x80, n=1, v=1, c=0, z=0, one cycle after accept. SUB 0x00−0x01 → 0xFF, c=1, v=0.
- SHL 0x81 by 1 → 0x02, c=1. SHR 0x80 by 3 → 0xF0, c=0. Shift by 0 → operand unchanged, c=0.
- MUL 0x10×0x11 → 0x10, c=1, out_valid 8 cycles after accept, in_ready=0 throughout. MUL 0x0F×0x0F → 0xE1, c=0.
- Backpressure: out_ready=0 for 5 cycles holds result/flags stable with in_ready=0. Raising out_ready together with in_valid (AND 0xF0,0x3C) gives 0x30 the next cycle with no bubble.
- Opcode 1010 → result 0, z=1, illegal=1. A following NOR 0x00,0x00 → 0xFF, n=1, illegal=0.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, iterative shift-add unsigned multiply.
// Result and flags are registered and held until the consumer takes them.
module seq_alu #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_result;
    logic                   r_z;
    logic                   r_n;
    logic                   r_c;
    logic                   r_v;
    logic                   r_ill;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [SHW:0]           r_cnt;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_is_mul;
    logic                   w_mul_last;
    logic [SHW-1:0]         w_shamt;
    logic [WIDTH:0]         w_add;
    logic [WIDTH:0]         w_sub;
    logic [WIDTH:0]         w_shl;
    logic signed [WIDTH:0]  w_shr_in;
    logic [WIDTH:0]         w_shr;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]       w_alu_res;
    logic                   w_alu_c;
    logic                   w_alu_v;
    logic                   w_alu_ill;
    logic                   w_load_en;
    logic [WIDTH-1:0]       w_load_res;
    logic                   w_load_c;
    logic                   w_load_v;
    logic                   w_load_ill;

    assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_is_mul   = (opcode == OP_MUL);
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_LAST);

    // Carry/borrow fall out of the extra MSB; shifts carry the last bit out in the extra bit.
    assign w_shamt    = operandB[SHW-1:0];
    assign w_add      = {1'b0, operandA} + {1'b0, operandB};
    assign w_sub      = {1'b0, operandA} - {1'b0, operandB};
    assign w_shl      = {1'b0, operandA} << w_shamt;
    assign w_shr_in   = $signed({operandA, 1'b0});
    assign w_shr      = w_shr_in >>> w_shamt;
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});

    // Single-cycle operation decode.
    always_comb begin
        w_alu_res = {WIDTH{1'b0}};
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_alu_ill = 1'b0;
        case (opcode)
            OP_AND:  w_alu_res = operandA & operandB;
            OP_OR:   w_alu_res = operandA | operandB;
            OP_NAND: w_alu_res = ~(operandA & operandB);
            OP_NOR:  w_alu_res = ~(operandA | operandB);
            OP_ADD: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_alu_c   = w_add[WIDTH];
                w_alu_v   = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                            (w_add[WIDTH-1] != operandA[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_sub[WIDTH-1:0];
                w_alu_c   = w_sub[WIDTH];
                w_alu_v   = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                            (w_sub[WIDTH-1] != operandA[WIDTH-1]);
            end
            OP_SHL: begin
                w_alu_res = w_shl[WIDTH-1:0];
                w_alu_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_alu_res = w_shr[WIDTH:1];
                w_alu_c   = w_shr[0];
            end
            OP_MUL:  w_alu_res = {WIDTH{1'b0}};
            default: w_alu_ill = 1'b1;
        endcase
    end

    // Select what, if anything, lands in the result register this cycle.
    always_comb begin
        w_load_en  = 1'b0;
        w_load_res = {WIDTH{1'b0}};
        w_load_c   = 1'b0;
        w_load_v   = 1'b0;
        w_load_ill = 1'b0;
        if (w_accept && !w_is_mul) begin
            w_load_en  = 1'b1;
            w_load_res = w_alu_res;
            w_load_c   = w_alu_c;
            w_load_v   = w_alu_v;
            w_load_ill = w_alu_ill;
        end else if (w_mul_last) begin
            w_load_en  = 1'b1;
            w_load_res = w_acc_next[WIDTH-1:0];
            w_load_c   = |w_acc_next[2*WIDTH-1:WIDTH];
        end else begin
            w_load_en  = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = w_is_mul ? S_MUL : S_DONE;
                else          w_state_next = S_IDLE;
            end
            S_MUL: begin
                if (w_mul_last) w_state_next = S_DONE;
                else            w_state_next = S_MUL;
            end
            S_DONE: begin
                if (!out_ready)    w_state_next = S_DONE;
                else if (w_accept) w_state_next = w_is_mul ? S_MUL : S_DONE;
                else               w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State and output-valid registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next == S_DONE);
        end
    end

    // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {(SHW+1){1'b0}};
        end else if (w_accept && w_is_mul) begin
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mcand  <= {{WIDTH{1'b0}}, operandA};
            r_mplier <= operandB;
            r_cnt    <= CNT_INIT;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_LAST;
        end else begin
            r_acc    <= r_acc;
        end
    end

    // Result and flag registers; z and n always follow the loaded result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= {WIDTH{1'b0}};
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_ill    <= 1'b0;
        end else if (w_load_en) begin
            r_result <= w_load_res;
            r_z      <= (w_load_res == {WIDTH{1'b0}});
            r_n      <= w_load_res[WIDTH-1];
            r_c      <= w_load_c;
            r_v      <= w_load_v;
            r_ill    <= w_load_ill;
        end else begin
            r_result <= r_result;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;
    assign flag_v    = r_v;
    assign illegal   = r_ill;

endmodule
